// File: rtl/pc_trace_buffer_if.sv
// Bus bundle between the PC trace FIFO and the host-side PIO ports.
// The master drives capture/control inputs; the slave (the FIFO) drives status.
interface pc_trace_buffer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] pc_in;
    logic                  pc_valid;
    logic                  enable;
    logic                  clear;
    logic                  pop;
    logic [DATA_WIDTH-1:0] pc_out;
    logic                  empty;
    logic                  full;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic [15:0]           drop_count;

    modport master (
        output pc_in, pc_valid, enable, clear, pop,
        input  pc_out, empty, full, count, overflow, drop_count
    );

    modport slave (
        input  pc_in, pc_valid, enable, clear, pop,
        output pc_out, empty, full, count, overflow, drop_count
    );
endinterface

// File: rtl/pc_trace_buffer.sv
// PC trace FIFO: captures core PCs (optionally de-duplicated), presents the
// oldest entry to a host input port, and dequeues on each rising edge of pop.
module pc_trace_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter bit          DEDUP      = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    pc_trace_buffer_if.slave   bus
);
    localparam logic [ADDR_WIDTH:0]   FullCount = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   CountOne  = 1;
    localparam logic [ADDR_WIDTH-1:0] PtrOne    = 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [15:0]           drop_q, drop_d;
    logic [DATA_WIDTH-1:0] last_pc_q, last_pc_d;
    logic                  last_vld_q, last_vld_d;
    logic                  pop_q;

    logic empty_s, full_s, pop_pulse, dedup_hit, cap;
    logic do_pop, do_push, do_drop, mem_we;

    // Request decode from registered state and current inputs.
    always_comb begin
        empty_s   = (count_q == '0);
        full_s    = (count_q == FullCount);
        pop_pulse = bus.pop & ~pop_q;
        dedup_hit = DEDUP && last_vld_q && (bus.pc_in == last_pc_q);
        cap       = bus.enable & bus.pc_valid & ~dedup_hit;
        do_pop    = pop_pulse & ~empty_s;
        // A same-cycle pop frees the slot the push needs.
        do_push   = cap & (~full_s | do_pop);
        do_drop   = cap & full_s & ~do_pop;
        mem_we    = do_push & ~bus.clear & ~reset;
    end

    // Next-state for pointers, occupancy and loss tracking; clear wins over all.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        last_pc_d  = last_pc_q;
        last_vld_d = last_vld_q;
        if (bus.clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
            last_vld_d = 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_d   = wr_ptr_q + PtrOne;
                last_pc_d  = bus.pc_in;
                last_vld_d = 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CountOne;
            end else if (do_pop && !do_push) begin
                count_d = count_q - CountOne;
            end
            if (do_drop) begin
                overflow_d = 1'b1;
                if (drop_q != 16'hFFFF) begin
                    drop_d = drop_q + 16'd1;
                end
            end
        end
    end

    // Control state register with synchronous reset; pop_q tracks pop even under clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            last_pc_q  <= '0;
            last_vld_q <= 1'b0;
            pop_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            last_pc_q  <= last_pc_d;
            last_vld_q <= last_vld_d;
            pop_q      <= bus.pop;
        end
    end

    // Entry storage; contents survive clear/reset since empty masks pc_out.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= bus.pc_in;
        end
    end

    assign bus.pc_out     = empty_s ? '0 : mem[rd_ptr_q];
    assign bus.empty      = empty_s;
    assign bus.full       = full_s;
    assign bus.count      = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.drop_count = drop_q;
endmodule

// File: doc/pc_trace_buffer.md
# pc_trace_buffer

Captures program-counter values from the monitored processor core into a small FIFO and presents the oldest captured PC to the SoC's 32-bit PC input port, which the Nios host reads over Avalon. The block sits directly upstream of that input port: its `pc_out` drives the port's `in_port`. Host software advances the FIFO through a PIO output bit wired to `pop`. Status outputs go to a second input port so the host can poll fill level and loss.

## Interface
- `DATA_WIDTH`, 32: PC width.
- `DEPTH`, 16: FIFO entries; must be a power of two, at least 2.
- `ADDR_WIDTH`, 4: log2(DEPTH).
- `DEDUP`, 1: when 1, a PC equal to the last captured PC is not stored.

Ports:
- `clk`  in  1  single clock domain; everything updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pc_in`  in  DATA_WIDTH  PC from the monitored core.
- `pc_valid`  in  1  `pc_in` valid this cycle.
- `enable`  in  1  capture enable (host PIO level).
- `clear`  in  1  synchronous flush (host PIO level); active every cycle it is high.
- `pop`  in  1  host PIO level; each rising edge requests one dequeue.
- `pc_out`  out  DATA_WIDTH  oldest entry; 0 when empty.
- `empty`  out  1  FIFO holds no entries.
- `full`  out  1  FIFO holds DEPTH entries.
- `count`  out  ADDR_WIDTH+1  number of entries, 0..DEPTH.
- `overflow`  out  1  sticky; set when a capture is dropped.
- `drop_count`  out  16  captures dropped, saturating at 0xFFFF.

## Operation
- **Storage.** Register array `mem[DEPTH]` with write pointer `wr_ptr` and read pointer `rd_ptr` (ADDR_WIDTH bits, natural wrap at DEPTH-1 → 0) plus `count` (ADDR_WIDTH+1 bits).
  - `empty` = (`count` == 0).
  - `full` = (`count` == DEPTH).
- **Capture request.** `cap` = `enable` & `pc_valid` & !(`DEDUP` & `last_vld` & (`pc_in` == `last_pc`)).
  - `last_pc` / `last_vld` update on every accepted push.
  - Dropped captures do not update them.
- **Pop request.** `pop_q` is `pop` registered; it resets to 0.
  - `pop_pulse` = `pop` & !`pop_q`.
  - `do_pop` = `pop_pulse` & !`empty`. A pop when empty is ignored, with no error.
- **Push acceptance.** `do_push` = `cap` & (!`full` | `do_pop`). A pop in the same cycle frees a slot for the push.
- **Drop on full.** `cap` & `full` & !`do_pop`:
  - the entry is not written;
  - `overflow` ← 1;
  - `drop_count` ← `drop_count` + 1, unless it is already 0xFFFF.
- **Count update.** `count` += `do_push` − `do_pop`. Push and pop together leave `count` unchanged and advance both pointers.
- **Empty with push and pop together.** `do_pop` is 0, so only the push occurs.
- **Clear.** `clear` = 1 has priority over every other action in that cycle:
  - pointers, `count`, `overflow`, `drop_count` and `last_vld` go to 0;
  - any concurrent push or pop is discarded;
  - `pop_q` still tracks `pop`;
  - `mem` contents are not cleared.
- **Output.** `pc_out` = `empty` ? 0 : `mem[rd_ptr]`, taken from registered state.
- **Reset.** Everything returns to its reset value on the next edge, including mid-stream. Outputs after reset:
  - `pc_out` = 0, `empty` = 1, `full` = 0, `count` = 0, `overflow` = 0, `drop_count` = 0;
  - `pop_q` = 0 and `last_vld` = 0.
- **`pop` high out of reset.** A `pop` held high as reset releases produces one `pop_pulse`. It is harmless because the FIFO is empty.

## Timing
- Push latency is one cycle. A capture sampled at edge N into an empty FIFO gives `empty` = 0 and `pc_out` = `pc_in` after edge N.
- Pop latency is one cycle from the `pop` edge being sampled.
  - `pop` rising, sampled at edge N, gives `pop_pulse` during the cycle ending at edge N.
  - The pointer advances at edge N; the new head is on `pc_out` after edge N.
- `pc_out` is stable between edges. The Avalon port adds its own one-cycle registered read on top of this.
- Throughput is one push per cycle and one pop per `pop` rising edge, so at most one pop every 2 cycles.
- Status outputs (`empty`, `full`, `count`, `overflow`, `drop_count`) are all registered or decoded from registered state and update on the same edge as the action.

## Test plan
- **Basic order.** Reset, `enable` = 1, push 0x1000, 0x1004, 0x1008 on consecutive cycles → `count` = 3 and `pc_out` = 0x1000. Three `pop` edges → `pc_out` shows 0x1004, then 0x1008, then 0 with `empty` = 1.
- **Dedup.** `DEDUP` = 1, `pc_valid` held 5 cycles with `pc_in` = 0x2000 → `count` = 1. Then 0x2004, then 0x2000 → `count` = 3.
- **Overflow.** Push 20 distinct PCs with no pops, `DEPTH` = 16 → `full` = 1, `count` = 16, `overflow` = 1, `drop_count` = 4, `pc_out` = first PC. Pop all 16 → `count` = 0 and `overflow` stays 1.
- **Full plus simultaneous push/pop.** With `full` = 1, a `pop` edge coincides with a new capture 0x3000 → `count` stays 16 and `drop_count` is unchanged. 0x3000 dequeues last, after the 16 older entries drain, with no loss.
- **Wrap-around.** 40 interleaved push/pop operations keeping `count` between 1 and 3 → output order matches input order across pointer wrap at index 15 → 0.
- **Clear and reset mid-stream.**
  - With 5 entries, `overflow` = 1 and a concurrent capture, assert `clear` for 1 cycle → `count` = 0, `empty` = 1, `overflow` = 0, `drop_count` = 0; the capture is lost.
  - Repeat the setup with `reset` instead → the same values result, and `pc_out` = 0.
  - `pop` held high during reset → after release, `count` stays 0.
